uart_prog_loader: RTL and testbench
===================================

# uart_prog_loader

Framed boot-loader stage directly downstream of the UART receiver. It consumes the received byte stream, parses a sync/length/payload/checksum frame, and assembles little-endian 32-bit words. It issues one instruction-memory write per word and holds the CPU stalled until a complete, checksum-valid image has been written.

## Interface
Parameters:
- IMEM_BASE, 32'h0000_0000, byte address of the first written word
- MAX_WORDS, 256, largest legal payload length in words (1..65535)
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 5_000_000, maximum idle gap between bytes inside a frame

Ports:
- CLK  in  1  system clock; everything is rising-edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  programming mode from the UART control register; low aborts the loader
- rx_valid  in  1  one-cycle strobe: rx_byte is valid
- rx_byte  in  8  received byte
- rx_err  in  1  framing error qualifier; valid together with rx_valid
- imem_WE  out  1  instruction-memory write strobe, one cycle per word
- imem_A  out  32  write byte address
- imem_WD  out  32  write data
- cpu_stall  out  1  holds the CPU while a load is incomplete
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a load completes successfully
- error  out  1  one-cycle pulse when a load is aborted by an error
- err_code  out  3  last error: 0 none, 1 bad length, 2 checksum, 3 timeout, 4 framing; holds its value until the next SYNC is accepted
- word_count  out  16  number of words written in the current or last frame

Reset values: every output is 0.

## Operation
- Frame format: SYNC, LEN_LO, LEN_HI, LEN×4 data bytes (LSB first per word), CHK.
- CHK is the XOR of every byte after SYNC, up to and including the last data byte.
- A byte is accepted only when rx_valid=1, rx_err=0 and enable=1.
- States: IDLE, LEN0, LEN1, DATA, CHK.
  - IDLE: an accepted byte equal to SYNC_BYTE moves to LEN0, sets cpu_stall, clears err_code, word_count, checksum and byte index. Any other byte is ignored.
  - LEN0: latch the low length byte, then go to LEN1.
  - LEN1: form the 16-bit LEN. If LEN=0 or LEN>MAX_WORDS, raise error code 1 and return to IDLE. Otherwise go to DATA.
  - DATA: shift each byte into the word register at lane index[1:0]. On lane 3, register the word write. After LEN words, go to CHK.
  - CHK: if the received byte equals the running XOR, pulse done, drop cpu_stall and go to IDLE. Otherwise raise error code 2 and go to IDLE.
- Write address: imem_A = IMEM_BASE + 4×word_index, 32-bit wrap-around. word_count increments on each write.
- Error behaviour:
  - Errors leave cpu_stall high, because memory is partially written, and return to IDLE.
  - Only a later good frame or enable=0 releases the stall.
  - rx_valid with rx_err=1 in a non-IDLE state raises error code 4. In IDLE it is ignored.
- Timeout: an inter-byte counter reloads on every accepted byte. If it reaches TIMEOUT_CYCLES in a non-IDLE state, raise error code 3 and go to IDLE.
- enable=0 in any state: go to IDLE next cycle, cpu_stall=0, no error pulse, err_code unchanged. Enable has priority over a simultaneous rx_valid.
- A SYNC_BYTE value received inside a frame is ordinary data and does not resynchronise.

## Timing
- imem_WE is high for exactly one cycle, the cycle after the 4th byte of a word is accepted. imem_A and imem_WD are stable in that cycle and hold until the next write.
- done and error are asserted the cycle after the CHK (or offending) byte is accepted, or after the timeout expires.
- cpu_stall rises the cycle after SYNC is accepted. It falls in the same cycle that done is high.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss: one byte per cycle of throughput.
- Reset asserted mid-frame: all state is cleared immediately (asynchronous), no write is issued, cpu_stall=0.

## Structure
- Shared package loader_pkg:
  - state enum: IDLE, LEN0, LEN1, DATA, CHK
  - err_code constants: ERR_NONE, ERR_LEN, ERR_CHK, ERR_TIMEOUT, ERR_FRAME
  - default SYNC_BYTE
- Single module; no sub-module. The timeout counter and word assembler are inline registers.
- The running checksum is an 8-bit register. The byte index is 18 bits (16-bit word index plus 2-bit lane).

## Test plan
- Good frame A5 02 00 | 78 56 34 12 | EF BE AD DE | CHK=0x02^0x00^…^0xDE, IMEM_BASE=0 → two writes (0x0 ← 0x12345678, 0x4 ← 0xDEADBEEF), done pulse, cpu_stall low, word_count=2.
- LEN=0 (A5 00 00) and LEN=MAX_WORDS+1 → error pulse, err_code=1, no write, cpu_stall high, then IDLE.
- Good payload with the CHK byte flipped → both writes occur, err_code=2, cpu_stall stays high; a subsequent good frame clears the stall.
- Stop mid-word after 2 data bytes for TIMEOUT_CYCLES → err_code=3, no partial write. The next A5 restarts the load cleanly.
- enable dropped mid-DATA on the same cycle as rx_valid → byte discarded, IDLE, cpu_stall=0, no error pulse. reset_n pulsed mid-frame → all outputs 0.
- Data bytes sent back-to-back every cycle, including an embedded 0xA5 → all bytes consumed as data, correct words written, done pulse.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader.
// Holds the parser state encoding, the error-code values reported on
// err_code, and the default frame start marker.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CHK     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_FRAME   = 3'd4;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
//   rx_valid/rx_byte/rx_err : received byte strobe, data, framing-error flag
//   imem_WE/imem_A/imem_WD  : one-cycle word write strobe, byte address, data
// slave  : the loader (consumes bytes, drives writes)
// master : the environment (drives bytes, observes writes)
interface uart_prog_loader_if ();
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_err;
  logic        imem_WE;
  logic [31:0] imem_A;
  logic [31:0] imem_WD;

  modport slave (
    input  rx_valid, rx_byte, rx_err,
    output imem_WE, imem_A, imem_WD
  );

  modport master (
    output rx_valid, rx_byte, rx_err,
    input  imem_WE, imem_A, imem_WD
  );
endinterface

// File: rtl/uart_prog_loader.sv
// Boot loader that parses SYNC / LEN_LO / LEN_HI / data / CHK frames from
// the UART byte stream, packs little-endian words and writes them to
// instruction memory, stalling the CPU until a checksum-valid image lands.
// Ports:
//   CLK, reset_n : clock, asynchronous active-low reset
//   enable       : programming mode; low aborts to IDLE and releases stall
//   bus          : byte input and imem write output (uart_prog_loader_if)
//   cpu_stall    : CPU hold while an image is incomplete or bad
//   busy         : parser not in IDLE
//   done, error  : one-cycle completion / abort pulses
//   err_code     : last error, cleared when a SYNC is accepted
//   word_count   : words written in the current or last frame
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 256,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int          TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                CLK,
  input  logic                reset_n,
  input  logic                enable,
  uart_prog_loader_if.slave   bus,
  output logic                cpu_stall,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2:0]          err_code,
  output logic [15:0]         word_count
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_W    = 17'(MAX_WORDS);

  state_t        state_q, state_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [15:0]   len_q, len_d;
  logic [17:0]   idx_q, idx_d;        // {word index, byte lane}
  logic [7:0]    chk_q, chk_d;
  logic [31:0]   word_q, word_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          imem_we_q, imem_we_d;
  logic [31:0]   imem_a_q, imem_a_d;
  logic [31:0]   imem_wd_q, imem_wd_d;
  logic          cpu_stall_q, cpu_stall_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [15:0]   word_count_q, word_count_d;

  logic acc_byte, bad_byte;

  assign acc_byte = bus.rx_valid & ~bus.rx_err;
  assign bad_byte = bus.rx_valid &  bus.rx_err;

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    idx_d        = idx_q;
    chk_d        = chk_q;
    word_d       = word_q;
    tmo_d        = tmo_q;
    imem_we_d    = 1'b0;
    imem_a_d     = imem_a_q;
    imem_wd_d    = imem_wd_q;
    cpu_stall_d  = cpu_stall_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    err_code_d   = err_code_q;
    word_count_d = word_count_q;

    if (!enable) begin
      // Abort wins over any byte arriving in the same cycle.
      state_d     = IDLE;
      cpu_stall_d = 1'b0;
      tmo_d       = '0;
    end else if (state_q == IDLE) begin
      tmo_d = '0;
      if (acc_byte && bus.rx_byte == SYNC_BYTE) begin
        state_d      = LEN0;
        cpu_stall_d  = 1'b1;
        err_code_d   = ERR_NONE;
        word_count_d = '0;
        chk_d        = '0;
        idx_d        = '0;
      end
    end else if (bad_byte) begin
      state_d    = IDLE;
      error_d    = 1'b1;
      err_code_d = ERR_FRAME;
    end else if (acc_byte) begin
      tmo_d = '0;
      chk_d = chk_q ^ bus.rx_byte;
      case (state_q)
        LEN0: begin
          len_lo_d = bus.rx_byte;
          state_d  = LEN1;
        end
        LEN1: begin
          len_d = {bus.rx_byte, len_lo_q};
          if (len_d == 16'd0 || {1'b0, len_d} > MAX_W) begin
            state_d    = IDLE;
            error_d    = 1'b1;
            err_code_d = ERR_LEN;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          word_d[{idx_q[1:0], 3'b000} +: 8] = bus.rx_byte;
          idx_d = idx_q + 18'd1;
          if (idx_q[1:0] == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_a_d     = IMEM_BASE + {14'd0, idx_q[17:2], 2'b00};
            imem_wd_d    = {bus.rx_byte, word_q[23:0]};
            word_count_d = word_count_q + 16'd1;
            if (idx_q[17:2] == len_q - 16'd1) state_d = CHK;
          end
        end
        CHK: begin
          state_d = IDLE;
          if (bus.rx_byte == chk_q) begin
            done_d      = 1'b1;
            cpu_stall_d = 1'b0;
          end else begin
            error_d    = 1'b1;
            err_code_d = ERR_CHK;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_q == TMO_LAST) begin
      state_d    = IDLE;
      tmo_d      = '0;
      error_d    = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      chk_q        <= '0;
      word_q       <= '0;
      tmo_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_a_q     <= '0;
      imem_wd_q    <= '0;
      cpu_stall_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      chk_q        <= chk_d;
      word_q       <= word_d;
      tmo_q        <= tmo_d;
      imem_we_q    <= imem_we_d;
      imem_a_q     <= imem_a_d;
      imem_wd_q    <= imem_wd_d;
      cpu_stall_q  <= cpu_stall_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      word_count_q <= word_count_d;
    end
  end

  assign bus.imem_WE = imem_we_q;
  assign bus.imem_A  = imem_a_q;
  assign bus.imem_WD = imem_wd_q;
  assign cpu_stall   = cpu_stall_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;
  import loader_pkg::*;

  localparam int TMO = 40;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        cpu_stall, busy, done, error;
  logic [2:0]  err_code;
  logic [15:0] word_count;

  uart_prog_loader_if bus ();

  uart_prog_loader #(
    .IMEM_BASE(32'h0000_0000),
    .MAX_WORDS(4),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(clk),
    .reset_n(reset_n),
    .enable(enable),
    .bus(bus),
    .cpu_stall(cpu_stall),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic is_err; logic [2:0] code; logic stall; logic [15:0] wc; } ev_t;

  wr_t wr_q[$];
  ev_t ev_q[$];
  logic [7:0] fq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wr_q.push_back(w);
  endtask

  task automatic exp_ev(input logic is_err, input logic [2:0] code, input logic stall, input logic [15:0] wc);
    ev_t e;
    e.is_err = is_err; e.code = code; e.stall = stall; e.wc = wc;
    ev_q.push_back(e);
  endtask

  // Monitor: compares every write and every done/error pulse against the queues.
  always @(posedge clk) begin
    #1;
    if (bus.imem_WE === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h want none", bus.imem_A, bus.imem_WD);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        $display("write addr=%h data=%h (expect %h %h)", bus.imem_A, bus.imem_WD, w.a, w.d);
        check("wr_addr", bus.imem_A, w.a);
        check("wr_data", bus.imem_WD, w.d);
      end
    end
    if (done === 1'b1 || error === 1'b1) begin
      if (ev_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_event: got done=%b error=%b code=%0d want none", done, error, err_code);
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        $display("event done=%b error=%b code=%0d stall=%b wc=%0d", done, error, err_code, cpu_stall, word_count);
        check("ev_error", {31'd0, error}, {31'd0, e.is_err});
        check("ev_done", {31'd0, done}, {31'd0, ~e.is_err});
        check("ev_code", {29'd0, err_code}, {29'd0, e.code});
        check("ev_stall", {31'd0, cpu_stall}, {31'd0, e.stall});
        check("ev_wcount", {16'd0, word_count}, {16'd0, e.wc});
      end
    end
  end

  task automatic send_fq(input int gap);
    for (int i = 0; i < fq.size(); i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b1; bus.rx_byte = fq[i]; bus.rx_err = 1'b0;
      if (gap > 0) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_a(input int gap);
    // CHK = 02^00^78^56^34^12^EF^BE^AD^DE = 0x28
    fq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
    exp_wr(32'h0, 32'h1234_5678);
    exp_wr(32'h4, 32'hDEAD_BEEF);
    exp_ev(1'b0, ERR_NONE, 1'b0, 16'd2);
    send_fq(gap);
    idle(3);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_byte = 8'h00; bus.rx_err = 1'b0;
    idle(3);
    // reset state
    check("rst_we", {31'd0, bus.imem_WE}, 32'd0);
    check("rst_addr", bus.imem_A, 32'd0);
    check("rst_data", bus.imem_WD, 32'd0);
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_code", {29'd0, err_code}, 32'd0);
    check("rst_wcount", {16'd0, word_count}, 32'd0);
    reset_n = 1'b1;
    idle(2);

    // good frame with gaps
    frame_a(1);
    check("a_stall", {31'd0, cpu_stall}, 32'd0);
    check("a_busy", {31'd0, busy}, 32'd0);

    // LEN = 0 and LEN = MAX_WORDS+1
    fq = '{8'hA5, 8'h00, 8'h00};
    exp_ev(1'b1, ERR_LEN, 1'b1, 16'd0);
    send_fq(0); idle(3);
    fq = '{8'hA5, 8'h05, 8'h00};
    exp_ev(1'b1, ERR_LEN, 1'b1, 16'd0);
    send_fq(0); idle(3);
    check("len_stall", {31'd0, cpu_stall}, 32'd1);
    check("len_busy", {31'd0, busy}, 32'd0);

    // bad checksum (good = 0x45, send 0xBA)
    fq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hBA};
    exp_wr(32'h0, 32'h4433_2211);
    exp_ev(1'b1, ERR_CHK, 1'b1, 16'd1);
    send_fq(0); idle(3);
    check("chk_stall", {31'd0, cpu_stall}, 32'd1);
    check("chk_code", {29'd0, err_code}, {29'd0, ERR_CHK});
    frame_a(0);
    check("chk_recover_stall", {31'd0, cpu_stall}, 32'd0);

    // timeout mid-word
    fq = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
    exp_ev(1'b1, ERR_TIMEOUT, 1'b1, 16'd0);
    send_fq(0);
    idle(TMO + 5);
    check("tmo_code", {29'd0, err_code}, {29'd0, ERR_TIMEOUT});
    check("tmo_stall", {31'd0, cpu_stall}, 32'd1);
    // restart: CHK = 01^00^01^02^03^04 = 0x05
    fq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    exp_wr(32'h0, 32'h0403_0201);
    exp_ev(1'b0, ERR_NONE, 1'b0, 16'd1);
    send_fq(0); idle(3);

    // framing error inside a frame
    fq = '{8'hA5, 8'h01, 8'h00};
    exp_ev(1'b1, ERR_FRAME, 1'b1, 16'd0);
    send_fq(0);
    bus.rx_valid = 1'b1; bus.rx_byte = 8'h00; bus.rx_err = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.rx_err = 1'b0;
    idle(3);
    check("frame_code", {29'd0, err_code}, {29'd0, ERR_FRAME});

    // enable dropped mid-DATA together with a byte
    fq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_wr(32'h0, 32'h4433_2211);
    send_fq(0);
    enable = 1'b0; bus.rx_valid = 1'b1; bus.rx_byte = 8'h66;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    idle(3);
    check("en_stall", {31'd0, cpu_stall}, 32'd0);
    check("en_busy", {31'd0, busy}, 32'd0);
    check("en_wcount", {16'd0, word_count}, 32'd1);
    check("en_code", {29'd0, err_code}, {29'd0, ERR_NONE});
    enable = 1'b1;
    idle(2);

    // reset mid-frame
    fq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    send_fq(0);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_wcount", {16'd0, word_count}, 32'd0);
    check("mid_rst_addr", bus.imem_A, 32'd0);
    idle(2);
    reset_n = 1'b1;
    fq = '{8'h44};
    send_fq(0); idle(3);

    // back-to-back with embedded SYNC values; CHK = 0x07
    fq = '{8'hA5, 8'h02, 8'h00, 8'hA5, 8'h01, 8'h02, 8'h03,
           8'h04, 8'hA5, 8'h06, 8'h07, 8'h07};
    exp_wr(32'h0, 32'h0302_01A5);
    exp_wr(32'h4, 32'h0706_A504);
    exp_ev(1'b0, ERR_NONE, 1'b0, 16'd2);
    send_fq(0); idle(4);
    check("b2b_stall", {31'd0, cpu_stall}, 32'd0);

    check("wr_left", wr_q.size(), 32'd0);
    check("ev_left", ev_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
